// File: rtl/keypad_emulator.sv
// Keypad emulator: queues key codes in an 8-entry FIFO and replays each one
// on a 3x3 row/column matrix for HOLD_CYCLES, then a GAP_CYCLES release.
// Optional macro KEYPAD_BOUNCE_EN adds a 4-phase contact-bounce lead-in.
// Ports: hwclk, reset (sync, active-high), key/key_valid/key_ready (queue),
// keypad_r1..r3 (row strobes in), keypad_c1..c3 (column returns out),
// busy, done (end-of-gap pulse), err (invalid key pulse).
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 120000,
  parameter int unsigned GAP_CYCLES    = 120000,
  parameter int unsigned BOUNCE_CYCLES = 1200
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       keypad_r1,
  input  logic       keypad_r2,
  input  logic       keypad_r3,
  output logic       keypad_c1,
  output logic       keypad_c2,
  output logic       keypad_c3,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [31:0] HOLD_N =
    (HOLD_CYCLES == 0) ? 32'd1 : 32'(HOLD_CYCLES);
  localparam logic [31:0] GAP_N =
    (GAP_CYCLES == 0) ? 32'd1 : 32'(GAP_CYCLES);

`ifdef KEYPAD_BOUNCE_EN
  localparam logic [31:0] BNC_N =
    (BOUNCE_CYCLES == 0) ? 32'd1 : 32'(BOUNCE_CYCLES);
`else
  logic unused_bounce;
  assign unused_bounce = |BOUNCE_CYCLES;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
`ifdef KEYPAD_BOUNCE_EN
    , ST_BOUNCE = 2'd3
`endif
  } state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [1:0]  row_q;
  logic [1:0]  col_q;
  logic        err_q;
  logic [3:0]  mem_q [8];
  logic [2:0]  wptr_q;
  logic [2:0]  rptr_q;
  logic [3:0]  count_q;
  logic [3:0]  count_d;
`ifdef KEYPAD_BOUNCE_EN
  logic [1:0]  phase_q;
`endif

  logic full;
  logic empty;
  logic key_ok;
  logic offer;
  logic push;
  logic pop;

  // {row, col} of a key; invalid codes never reach the FIFO
  function automatic logic [3:0] key_map(input logic [3:0] k);
    case (k)
      4'd1:    key_map = 4'b00_00;
      4'd2:    key_map = 4'b00_01;
      4'd3:    key_map = 4'b00_10;
      4'd4:    key_map = 4'b01_00;
      4'd5:    key_map = 4'b01_01;
      4'd6:    key_map = 4'b01_10;
      4'd7:    key_map = 4'b10_00;
      4'd8:    key_map = 4'b10_01;
      4'd9:    key_map = 4'b10_10;
      default: key_map = 4'b00_00;
    endcase
  endfunction

  assign full      = (count_q == 4'd8);
  assign empty     = (count_q == 4'd0);
  assign key_ok    = (key != 4'd0) && (key <= 4'd9);
  assign offer     = key_valid && !full;
  assign push      = offer && key_ok;
  assign pop       = (state_q == ST_IDLE) && !empty;
  assign key_ready = !full;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (push && !reset) begin
      mem_q[wptr_q] <= key;
    end
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 32'd0;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      err_q   <= 1'b0;
      wptr_q  <= 3'd0;
      rptr_q  <= 3'd0;
      count_q <= 4'd0;
`ifdef KEYPAD_BOUNCE_EN
      phase_q <= 2'd0;
`endif
    end else begin
      err_q   <= offer && !key_ok;
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + 3'd1;
      if (pop)  rptr_q <= rptr_q + 3'd1;
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            {row_q, col_q} <= key_map(mem_q[rptr_q]);
`ifdef KEYPAD_BOUNCE_EN
            state_q <= ST_BOUNCE;
            cnt_q   <= BNC_N;
            phase_q <= 2'd0;
`else
            state_q <= ST_PRESS;
            cnt_q   <= HOLD_N;
`endif
          end
        end
`ifdef KEYPAD_BOUNCE_EN
        ST_BOUNCE: begin
          if (cnt_q == 32'd1) begin
            if (phase_q == 2'd3) begin
              state_q <= ST_PRESS;
              cnt_q   <= HOLD_N;
            end else begin
              phase_q <= phase_q + 2'd1;
              cnt_q   <= BNC_N;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
`endif
        ST_PRESS: begin
          if (cnt_q == 32'd1) begin
            state_q <= ST_GAP;
            cnt_q   <= GAP_N;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == 32'd1) begin
            state_q <= ST_IDLE;
            cnt_q   <= 32'd0;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 32'd0;
        end
      endcase
    end
  end

  // Column drive is a pure gate of the live row strobe: zero latency.
  logic       gate;
  logic       r_sel;
  logic [2:0] cols;

  always_comb begin
`ifdef KEYPAD_BOUNCE_EN
    gate = (state_q == ST_PRESS) ||
           ((state_q == ST_BOUNCE) && !phase_q[0]);
`else
    gate = (state_q == ST_PRESS);
`endif
    r_sel = 1'b0;
    unique case (row_q)
      2'd0:    r_sel = keypad_r1;
      2'd1:    r_sel = keypad_r2;
      2'd2:    r_sel = keypad_r3;
      default: r_sel = 1'b0;
    endcase
    cols = (gate && r_sel) ? (3'b001 << col_q) : 3'b000;
  end

  assign keypad_c1 = cols[0];
  assign keypad_c2 = cols[1];
  assign keypad_c3 = cols[2];
  assign busy      = (state_q != ST_IDLE) || !empty;
  assign done      = (state_q == ST_GAP) && (cnt_q == 32'd1);
  assign err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator.
// Short hold/gap/bounce parameters keep the run brief.
module tb_keypad_emulator;

  localparam int H = 40;
  localparam int G = 10;
  localparam int B = 3;
`ifdef KEYPAD_BOUNCE_EN
  localparam int BT = 4 * B;
`else
  localparam int BT = 0;
`endif
  localparam int P = BT + H + G + 1;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key = 4'd0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic       r1 = 1'b0;
  logic       r2 = 1'b0;
  logic       r3 = 1'b0;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       busy;
  logic       done;
  logic       err;

  int errs = 0;
  int checks = 0;

  logic [3:0] sk [3];
  int         sr [3];
  int         sc [3];

  keypad_emulator #(
    .HOLD_CYCLES  (H),
    .GAP_CYCLES   (G),
    .BOUNCE_CYCLES(B)
  ) dut (
    .hwclk    (hwclk),
    .reset    (reset),
    .key      (key),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .keypad_r1(r1),
    .keypad_r2(r2),
    .keypad_r3(r3),
    .keypad_c1(c1),
    .keypad_c2(c2),
    .keypad_c3(c3),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 hwclk = ~hwclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge hwclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_valid = 1'b0;
    {r3, r2, r1} = 3'b000;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic gate(input int off);
    if (off < BT) return ((off / B) % 2) == 0;
    return off < BT + H;
  endfunction

  function automatic logic [2:0] rowpat(input int i);
    case (i % 4)
      0:       return 3'b001;
      1:       return 3'b010;
      2:       return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  // Push sk[0..nk-1] on consecutive edges and follow every cycle.
  task automatic run_seq(input int nk, input string tag);
    int n;
    n = nk * P + 4;
    key = sk[0];
    key_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic [2:0] rp;
      logic [2:0] ec;
      logic       ed;
      logic       eb;
      int         j;
      int         off;
      step();
      if (i + 1 < nk) key = sk[i+1];
      else key_valid = 1'b0;
      rp = rowpat(i);
      {r3, r2, r1} = rp;
      #1;
      ec = 3'b000;
      ed = 1'b0;
      eb = 1'b0;
      if (i == 0) begin
        eb = 1'b1;
      end else begin
        j = (i - 1) / P;
        off = (i - 1) % P;
        if (j < nk) begin
          eb = !((off == P - 1) && (j == nk - 1));
          ed = (off == P - 2);
          if (gate(off) && rp[sr[j]]) ec = 3'b001 << sc[j];
        end
      end
      check({tag, " cols"}, 32'({c3, c2, c1}), 32'(ec));
      check({tag, " done"}, 32'(done), 32'(ed));
      check({tag, " busy"}, 32'(busy), 32'(eb));
    end
  endtask

  initial begin
    do_reset();
    {r3, r2, r1} = 3'b111;
    #1;
    check("rst ready", 32'(key_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst cols", 32'({c3, c2, c1}), 32'd0);

    sk[0] = 4'd5; sr[0] = 1; sc[0] = 1;
    run_seq(1, "k5");

    sk[0] = 4'd1; sr[0] = 0; sc[0] = 0;
    sk[1] = 4'd9; sr[1] = 2; sc[1] = 2;
    sk[2] = 4'd3; sr[2] = 0; sc[2] = 2;
    run_seq(3, "k193");

    sk[0] = 4'd7; sr[0] = 2; sc[0] = 0;
    run_seq(1, "k7");

    // invalid codes
    do_reset();
    key = 4'd0;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("inv0 err", 32'(err), 32'd1);
    check("inv0 busy", 32'(busy), 32'd0);
    check("inv0 ready", 32'(key_ready), 32'd1);
    step();
    check("inv gap err", 32'(err), 32'd0);
    key = 4'd12;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    check("inv12 err", 32'(err), 32'd1);
    check("inv12 busy", 32'(busy), 32'd0);
    step();
    check("inv end err", 32'(err), 32'd0);
    step();
    check("inv end busy", 32'(busy), 32'd0);

    // fill the FIFO while key 2 is held
    do_reset();
    key = 4'd2;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    step();
    for (int n = 0; n < 9; n++) begin
      key = 4'(n + 1);
      key_valid = 1'b1;
      step();
      check($sformatf("fill%0d err", n), 32'(err), 32'd0);
      check($sformatf("fill%0d ready", n), 32'(key_ready),
            32'(n + 1 < 8));
    end
    for (int n = 0; n < 3; n++) begin
      step();
      check("full ready", 32'(key_ready), 32'd0);
      check("full err", 32'(err), 32'd0);
      check("full busy", 32'(busy), 32'd1);
    end
    key_valid = 1'b0;

    // reset in the middle of key 4 (r2 -> c1)
    do_reset();
    key = 4'd4;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    {r3, r2, r1} = 3'b010;
    repeat (20) step();
    check("k4 c1 held", 32'(c1), 32'd1);
    reset = 1'b1;
    step();
    check("k4 rst c1", 32'(c1), 32'd0);
    check("k4 rst busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < P + 5; i++) begin
      step();
      check("k4 no done", 32'(done), 32'd0);
      check("k4 no c1", 32'(c1), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
